intr_timer_ctrl: RTL and testbench

Interrupt source block that sits directly upstream of the processor top and drives its `t_interrupt` and `e_interrupt` inputs. It contains:
- a prescaled 32-bit machine timer with a compare register;
- a synchronizer and edge/level detector for one asynchronous external interrupt pin;
- pending latches that are cleared by a core acknowledge pulse or by a software write.

Software configures the block through a small word-addressed register port.

---
 rtl/intr_timer_ctrl.sv | 80 ++++++++
 tb/tb_intr_timer_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/intr_timer_ctrl.sv
// intr_timer_ctrl: prescaled 32-bit machine timer and external interrupt detector feeding the core's t/e interrupts.
// Define INTR_TIMER_AUTORELOAD_EN to reload MTIME to 0 on every compare match (periodic timer).
module intr_timer_ctrl #(
    parameter int PRESCALE    = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [1:0]  wr_addr,
    input  logic [31:0] wr_data,
    input  logic        rd_en,
    input  logic [1:0]  rd_addr,
    output logic [31:0] rd_data,
    input  logic        ext_irq_in,
    input  logic        t_ack,
    input  logic        e_ack,
    output logic        t_interrupt,
    output logic        e_interrupt
);
    localparam logic [15:0] PS_MAX = 16'(PRESCALE - 1);

    logic [31:0] mtime, mtimecmp, nxt, mtime_tick, rd_mux;
    logic [15:0] presc;
    logic [2:0]  ctrl;
    logic [SYNC_STAGES-1:0] sync_q;
    logic t_pending, e_pending, tick, match, sync, prev, e_set, t_clr, e_clr;
    logic wr_mtime, wr_cmp, wr_ctrl, wr_status;

    always_comb begin
        wr_mtime   = wr_en && wr_addr == 2'd0;
        wr_cmp     = wr_en && wr_addr == 2'd1;
        wr_ctrl    = wr_en && wr_addr == 2'd2;
        wr_status  = wr_en && wr_addr == 2'd3;
        tick       = ctrl[0] && presc == PS_MAX;
        nxt        = mtime + 32'd1;
        match      = tick && nxt == mtimecmp;
`ifdef INTR_TIMER_AUTORELOAD_EN
        mtime_tick = match ? 32'd0 : nxt;
`else
        mtime_tick = nxt;
`endif
        sync       = sync_q[SYNC_STAGES-1];
        // Edge mode only fires on the synchronized 0->1 transition; level mode fires every cycle
        e_set      = ctrl[1] && sync && (!ctrl[2] || !prev);
        t_clr      = t_ack || (wr_status && wr_data[0]);
        e_clr      = e_ack || (wr_status && wr_data[1]);
        rd_mux     = rd_addr == 2'd0 ? mtime :
                     rd_addr == 2'd1 ? mtimecmp :
                     rd_addr == 2'd2 ? {29'd0, ctrl} : {30'd0, e_pending, t_pending};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mtime     <= '0;
            mtimecmp  <= '1;
            ctrl      <= '0;
            presc     <= '0;
            t_pending <= 1'b0;
            e_pending <= 1'b0;
            sync_q    <= '0;
            prev      <= 1'b0;
            rd_data   <= '0;
        end else begin
            presc     <= (wr_mtime || tick) ? 16'd0 : ctrl[0] ? presc + 16'd1 : presc;
            mtime     <= wr_mtime ? wr_data : tick ? mtime_tick : mtime;
            mtimecmp  <= wr_cmp ? wr_data : mtimecmp;
            ctrl      <= wr_ctrl ? wr_data[2:0] : ctrl;
            // A set in the same cycle as a clear wins
            t_pending <= match || (t_pending && !t_clr);
            e_pending <= e_set || (e_pending && !e_clr);
            sync_q    <= {sync_q[SYNC_STAGES-2:0], ext_irq_in};
            prev      <= sync;
            rd_data   <= rd_en ? rd_mux : rd_data;
        end
    end

    assign t_interrupt = t_pending;
    assign e_interrupt = e_pending;
endmodule

// File: tb/tb_intr_timer_ctrl.sv
// tb_intr_timer_ctrl: directed bench for intr_timer_ctrl (PRESCALE=4, SYNC_STAGES=2).
module tb_intr_timer_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        wr_en = 1'b0;
    logic [1:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic        rd_en = 1'b0;
    logic [1:0]  rd_addr = '0;
    logic [31:0] rd_data;
    logic        ext_irq_in = 1'b0;
    logic        t_ack = 1'b0;
    logic        e_ack = 1'b0;
    logic        t_interrupt, e_interrupt;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t q[$];
    int   passed = 0;
    int   total = 0;
    int   fails = 0;

`ifdef INTR_TIMER_AUTORELOAD_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    intr_timer_ctrl #(.PRESCALE(4), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .ext_irq_in(ext_irq_in), .t_ack(t_ack), .e_ack(e_ack),
        .t_interrupt(t_interrupt), .e_interrupt(e_interrupt)
    );

    always #5 clk = ~clk;

    task automatic expect_val(input string tag, input logic [31:0] v);
        q.push_back('{tag, v});
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        total++;
        if (q.size() == 0) begin
            fails++;
            $display("FAIL scoreboard_empty: observed %h required an expected entry", obs);
        end else begin
            e = q.pop_front();
            assert (obs === e.val) passed++;
            else begin
                fails++;
                $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        cycles(1);
        wr_en = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, input string tag, input logic [31:0] v);
        expect_val(tag, v);
        rd_en = 1'b1; rd_addr = a;
        cycles(1);
        rd_en = 1'b0;
        check(rd_data);
    endtask

    initial begin
        #2 reset = 1'b1;
        expect_val("por_t_int", 0); expect_val("por_e_int", 0); expect_val("por_rd", 0);
        #1;
        check(t_interrupt); check(e_interrupt); check(rd_data);
        @(negedge clk) reset = 1'b0;
        cycles(1);
        rd(2'd1, "por_mtimecmp", 32'hFFFF_FFFF);

        // Timer match: CMP=3, PRESCALE=4 -> interrupt 12 edges after the CTRL write edge
        wr(2'd1, 32'd3);
        wr(2'd2, 32'd1);
        expect_val("match_e11", 0);
        cycles(11); check(t_interrupt);
        expect_val("match_e12", 1);
        cycles(1); check(t_interrupt);
        expect_val("t_ack_clear", 0);
        t_ack = 1'b1; cycles(1); t_ack = 1'b0;
        check(t_interrupt);
        rd(2'd0, "mtime_after_match", AR ? 32'd0 : 32'd3);
        cycles(2);
        rd(2'd0, "mtime_next_tick", AR ? 32'd1 : 32'd4);
        expect_val("second_match", AR ? 32'd1 : 32'd0);
        cycles(7); check(t_interrupt);
        wr(2'd2, 32'd0);
        wr(2'd3, 32'd1);
        expect_val("w1c_t_only", 0);
        check(t_interrupt);

        // External edge mode: one set, ack keeps it cleared while the pin stays high
        wr(2'd2, 32'b110);
        ext_irq_in = 1'b1;
        expect_val("edge_e2", 0);
        cycles(2); check(e_interrupt);
        expect_val("edge_e3", 1);
        cycles(1); check(e_interrupt);
        expect_val("edge_ack", 0);
        e_ack = 1'b1; cycles(1); e_ack = 1'b0;
        check(e_interrupt);
        expect_val("edge_stays_low", 0);
        cycles(6); check(e_interrupt);
        ext_irq_in = 1'b0;
        cycles(3);

        // External level mode: ack cannot clear while the pin stays high
        wr(2'd2, 32'b010);
        ext_irq_in = 1'b1;
        expect_val("level_e2", 0);
        cycles(2); check(e_interrupt);
        expect_val("level_e3", 1);
        cycles(1); check(e_interrupt);
        expect_val("level_reassert", 1);
        e_ack = 1'b1; cycles(1); e_ack = 1'b0;
        check(e_interrupt);
        ext_irq_in = 1'b0;
        cycles(3);

        // Wrap-around match, then ack colliding with a match
        wr(2'd0, 32'hFFFF_FFFF);
        wr(2'd1, 32'd0);
        wr(2'd2, 32'd1);
        expect_val("wrap_f3", 0);
        cycles(3); check(t_interrupt);
        expect_val("wrap_f4", 1);
        cycles(1); check(t_interrupt);
        rd(2'd0, "mtime_wrapped", 32'd0);
        wr(2'd1, 32'd2);
        expect_val("wrap_ack", 0);
        t_ack = 1'b1; cycles(1); t_ack = 1'b0;
        check(t_interrupt);
        cycles(4);
        expect_val("set_beats_ack", 1);
        t_ack = 1'b1; cycles(1); t_ack = 1'b0;
        check(t_interrupt);
        wr(2'd2, 32'd0);

        // Software clear of both pending bits
        expect_val("both_t", 1); expect_val("both_e", 1);
        check(t_interrupt); check(e_interrupt);
        rd(2'd3, "status_both", 32'd3);
        wr(2'd3, 32'd3);
        expect_val("w1c_t", 0); expect_val("w1c_e", 0);
        check(t_interrupt); check(e_interrupt);
        rd(2'd3, "status_cleared", 32'd0);

        // Asynchronous reset mid-count
        rd(2'd1, "cmp_before_reset", 32'd2);
        wr(2'd2, 32'b011);
        ext_irq_in = 1'b1;
        expect_val("pre_reset_e", 1);
        cycles(3); check(e_interrupt);
        #2 reset = 1'b1;
        expect_val("async_t", 0); expect_val("async_e", 0); expect_val("async_rd", 0);
        #1;
        check(t_interrupt); check(e_interrupt); check(rd_data);
        ext_irq_in = 1'b0;
        @(negedge clk) reset = 1'b0;
        cycles(1);
        rd(2'd1, "rst_mtimecmp", 32'hFFFF_FFFF);
        rd(2'd2, "rst_ctrl", 32'd0);
        rd(2'd0, "rst_mtime", 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
